// File: rtl/load_sched.sv
// Round-robin owner of a load/increment datapath: one LOAD cycle then RUN_LEN increment cycles per grant.
// Grant 1 cycle after req from IDLE; owner dropping req in RUN releases at once; losers wait in req.
module load_sched #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int RUN_LEN = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    sel,
  output logic [DW-1:0]           load_data,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] owner
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(RUN_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic            r_sel;
  logic [DW-1:0]   r_load_data;
  logic            r_busy;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_last;
  logic [CW-1:0]   r_cnt;

  logic [NREQ-1:0] w_gnt_nxt;
  logic [NREQ-1:0] w_done_nxt;
  logic            w_sel_nxt;
  logic [DW-1:0]   w_load_nxt;
  logic            w_busy_nxt;
  logic [IW-1:0]   w_owner_nxt;
  logic [IW-1:0]   w_last_nxt;
  logic [CW-1:0]   w_cnt_nxt;

  logic            w_any;
  logic [IW-1:0]   w_win;
  logic [IW:0]     w_cand;

  assign w_any = |req;

  // Scan farthest-to-nearest from last+1 so the nearest requester is the final assignment.
  always_comb begin
    w_win  = r_last;
    w_cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = {1'b0, r_last} + (IW+1)'(k);
      if (w_cand >= (IW+1)'(NREQ)) begin
        w_cand = w_cand - (IW+1)'(NREQ);
      end
      if (req[w_cand[IW-1:0]]) begin
        w_win = w_cand[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!req[r_owner] || (r_cnt == CW'(1))) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_gnt_nxt   = '0;
    w_done_nxt  = '0;
    w_sel_nxt   = 1'b0;
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_load_nxt  = r_load_data;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_owner_nxt      = w_win;
          w_last_nxt       = w_win;
          w_load_nxt       = req_data[int'(w_win)*DW +: DW];
          w_sel_nxt        = 1'b1;
          w_gnt_nxt[w_win] = 1'b1;
        end
      end
      S_LOAD: begin
        w_cnt_nxt = CW'(RUN_LEN);
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt - CW'(1);
      end
      default: begin
        w_cnt_nxt = '0;
      end
    endcase
    // done is registered, so raise it on entry to the RUN cycle whose count is 1.
    if ((w_state_nxt == S_RUN) && (w_cnt_nxt == CW'(1))) begin
      w_done_nxt[r_owner] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_gnt       <= '0;
      r_done      <= '0;
      r_sel       <= 1'b0;
      r_load_data <= '0;
      r_busy      <= 1'b0;
      r_owner     <= '0;
      r_last      <= IW'(NREQ - 1);
      r_cnt       <= '0;
    end else begin
      r_gnt       <= w_gnt_nxt;
      r_done      <= w_done_nxt;
      r_sel       <= w_sel_nxt;
      r_load_data <= w_load_nxt;
      r_busy      <= w_busy_nxt;
      r_owner     <= w_owner_nxt;
      r_last      <= w_last_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign sel       = r_sel;
  assign load_data = r_load_data;
  assign busy      = r_busy;
  assign owner     = r_owner;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(r_gnt));
  a_done_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(r_done));
  a_gnt_done_excl: assert property (@(posedge clk) disable iff (!rstn) !((|r_gnt) && (|r_done)));

endmodule

// File: tb/tb_load_sched.sv
// Bench for load_sched: table of single-requester loads plus RR, abort, reset and pending sequences.
`timescale 1ns/1ps
module tb_load_sched;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int RUN_LEN = 8;
  localparam int IW      = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              sel;
  logic [DW-1:0]     load_data;
  logic              busy;
  logic [IW-1:0]     owner;

  load_sched #(.NREQ(NREQ), .DW(DW), .RUN_LEN(RUN_LEN)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .done      (done),
    .sel       (sel),
    .load_data (load_data),
    .busy      (busy),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model of the downstream load/increment register.
  logic [DW-1:0] dp;
  always @(posedge clk or negedge rstn) begin
    if (!rstn)    dp <= '0;
    else if (sel) dp <= load_data;
    else          dp <= dp + 8'd1;
  end

  typedef struct {
    int         idx;
    logic [7:0] data;
  } gexp_t;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic [7:0] end_val;
  } vec_t;

  gexp_t q_gnt[$];
  int    q_done[$];
  gexp_t g;
  int    d;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (|gnt) begin
        at = cyc;
        break;
      end
    end
    chk("gnt_within_bound", (at >= 0), 1);
  endtask

  task automatic wait_done(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (|done) begin
        at = cyc;
        break;
      end
    end
    chk("done_within_bound", (at >= 0), 1);
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    req      = '0;
    req_data = '0;
    step();
    step();
    rstn = 1'b1;
    step();
  endtask

  // Scoreboard: every grant/done pulse must match the next expected entry.
  always @(negedge clk) begin
    if (rstn) begin
      if (|gnt) begin
        if (q_gnt.size() == 0) begin
          chk("sb_gnt_unexpected", gnt, 0);
        end else begin
          g = q_gnt.pop_front();
          chk("sb_gnt", gnt, 1 << g.idx);
          chk("sb_load_data", load_data, g.data);
          chk("sb_owner", owner, g.idx);
          chk("sb_sel_in_load", sel, 1);
        end
        chk("sb_gnt_done_excl", done, 0);
      end
      if (|done) begin
        if (q_done.size() == 0) begin
          chk("sb_done_unexpected", done, 0);
        end else begin
          d = q_done.pop_front();
          chk("sb_done", done, 1 << d);
        end
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  vec_t vecs[4];
  int   t0, t1, tprev, c0;

  initial begin
    vecs[0] = '{idx: 2, data: 8'h05, end_val: 8'h0C};
    vecs[1] = '{idx: 0, data: 8'hFD, end_val: 8'h04};
    vecs[2] = '{idx: 3, data: 8'h7F, end_val: 8'h86};
    vecs[3] = '{idx: 1, data: 8'hFF, end_val: 8'h06};

    rstn     = 1'b0;
    req      = '0;
    req_data = '0;
    step();
    step();
    chk("rst_sel", sel, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_load_data", load_data, 0);
    rstn = 1'b1;
    step();

    // Single-requester table: load, 8 RUN cycles, done on the last, then IDLE.
    for (int v = 0; v < 4; v++) begin
      req_data[vecs[v].idx*DW +: DW] = vecs[v].data;
      req[vecs[v].idx] = 1'b1;
      q_gnt.push_back('{idx: vecs[v].idx, data: vecs[v].data});
      q_done.push_back(vecs[v].idx);
      c0 = cyc;
      wait_gnt(4, t0);
      chk("tbl_grant_latency", t0 - c0, 1);
      chk("tbl_c1_sel", sel, 1);
      chk("tbl_c1_busy", busy, 1);
      chk("tbl_c1_load_data", load_data, vecs[v].data);
      for (int k = 2; k <= RUN_LEN + 1; k++) begin
        step();
        chk("tbl_run_sel", sel, 0);
        chk("tbl_run_busy", busy, 1);
        chk("tbl_run_owner", owner, vecs[v].idx);
        if (k == 2) chk("tbl_dp_first", dp, vecs[v].data);
        if (k == RUN_LEN + 1) begin
          chk("tbl_done_last", done, 1 << vecs[v].idx);
          chk("tbl_dp_last", dp, vecs[v].end_val);
        end else begin
          chk("tbl_no_early_done", done, 0);
        end
      end
      req[vecs[v].idx] = 1'b0;
      step();
      chk("tbl_idle_busy", busy, 0);
      chk("tbl_idle_done", done, 0);
    end

    // Round-robin with all requests held: 0,1,2,3,0 at 10-cycle spacing.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*DW +: DW] = 8'(8'h10 + i);
      q_gnt.push_back('{idx: i, data: 8'(8'h10 + i)});
      q_done.push_back(i);
    end
    q_gnt.push_back('{idx: 0, data: 8'h10});
    req   = 4'hF;
    tprev = 0;
    for (int n = 0; n < 5; n++) begin
      wait_gnt(RUN_LEN + 4, t0);
      if (n > 0) chk("rr_spacing", t0 - tprev, RUN_LEN + 2);
      tprev = t0;
    end
    req = '0;
    step();
    step();
    chk("rr_abort_busy", busy, 0);

    // Abort: owner 1 drops req in its 3rd RUN cycle; pending 3 follows.
    req_data[1*DW +: DW] = 8'h21;
    req[1] = 1'b1;
    q_gnt.push_back('{idx: 1, data: 8'h21});
    wait_gnt(4, t0);
    req_data[3*DW +: DW] = 8'h33;
    req[3] = 1'b1;
    q_gnt.push_back('{idx: 3, data: 8'h33});
    q_done.push_back(3);
    for (int k = 2; k <= 4; k++) begin
      step();
      chk("abort_run_busy", busy, 1);
      chk("abort_no_done", done, 0);
    end
    req[1] = 1'b0;
    step();
    chk("abort_busy_low", busy, 0);
    chk("abort_done_low", done, 0);
    c0 = cyc;
    wait_gnt(4, t0);
    chk("abort_pending_gnt", gnt, 4'b1000);
    chk("abort_pending_latency", t0 - c0, 1);
    wait_done(RUN_LEN + 4, t1);
    req[3] = 1'b0;
    step();

    // Asynchronous reset in RUN, then requester 0 wins over 3.
    req_data[2*DW +: DW] = 8'h44;
    req[2] = 1'b1;
    q_gnt.push_back('{idx: 2, data: 8'h44});
    wait_gnt(4, t0);
    step();
    step();
    rstn = 1'b0;
    #1;
    chk("midrst_sel", sel, 0);
    chk("midrst_gnt", gnt, 0);
    chk("midrst_done", done, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_owner", owner, 0);
    chk("midrst_load_data", load_data, 0);
    req = 4'b1001;
    req_data[0*DW +: DW] = 8'h50;
    req_data[3*DW +: DW] = 8'h53;
    step();
    step();
    q_gnt.push_back('{idx: 0, data: 8'h50});
    rstn = 1'b1;
    wait_gnt(4, t0);
    chk("midrst_winner", gnt, 4'b0001);
    req = '0;
    step();
    step();
    chk("midrst_abort_busy", busy, 0);

    // Pending while busy: req 1 rises in 0's LOAD; its data sampled in the IDLE gap.
    req_data[0*DW +: DW] = 8'h60;
    req[0] = 1'b1;
    q_gnt.push_back('{idx: 0, data: 8'h60});
    q_done.push_back(0);
    wait_gnt(4, t0);
    req_data[1*DW +: DW] = 8'h61;
    req[1] = 1'b1;
    wait_done(RUN_LEN + 4, t1);
    chk("pend_done_owner0", done, 4'b0001);
    req[0] = 1'b0;
    req_data[1*DW +: DW] = 8'h71;
    q_gnt.push_back('{idx: 1, data: 8'h71});
    step();
    chk("pend_idle_gnt", gnt, 0);
    chk("pend_idle_busy", busy, 0);
    step();
    chk("pend_gnt1", gnt, 4'b0010);
    chk("pend_gap", cyc - t1, 2);
    req_data[1*DW +: DW] = 8'h99;
    req[1] = 1'b0;
    step();
    chk("pend_dp_loaded", dp, 8'h71);
    step();
    chk("pend_final_busy", busy, 0);

    step();
    chk("sb_gnt_drained", q_gnt.size(), 0);
    chk("sb_done_drained", q_done.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_sched.md
# load_sched

Round-robin scheduler that shares the load port of the 8-bit load/increment counter datapath among `NREQ` requesters. A winning requester gets one load cycle (`sel`=1 with its value on `load_data`) followed by a fixed run window of `RUN_LEN` increment cycles (`sel`=0). When the window ends, the scheduler releases the datapath. The block sits directly in front of the datapath's `sel`/`data` inputs; no other logic drives them.

## Interface

Parameters:

- `NREQ`, 4: number of requesters, ≥2.
- `DW`, 8: load data width; matches the datapath.
- `RUN_LEN`, 8: increment cycles granted per load, ≥1.

Ports:

- `clk` input 1: single clock; all state updates on the rising edge.
- `rstn` input 1: reset, asynchronous, active-low.
- `req` input NREQ: request per requester; level, held until `done` or abandoned.
- `req_data` input NREQ*DW: flat load values; requester i at bits [i*DW +: DW].
- `gnt` output NREQ: one-cycle pulse, one-hot, in the LOAD cycle.
- `done` output NREQ: one-cycle pulse, one-hot, in the final RUN cycle.
- `sel` output 1: to datapath `sel`; 1 only in LOAD.
- `load_data` output DW: to datapath `data`; valid when `sel`=1.
- `busy` output 1: 1 in LOAD and RUN.
- `owner` output $clog2(NREQ): index of the current/last granted requester.

## Operation

- All outputs are registered.
- Reset values: `sel`=0, `load_data`=0, `gnt`=0, `done`=0, `busy`=0, `owner`=0.
  - Internal state resets to IDLE, run counter to 0, RR pointer `last`=NREQ-1, so requester 0 has top priority first.
- FSM states: IDLE, LOAD, RUN.
- **IDLE**
  - If no `req` bit is set, stay in IDLE.
  - Otherwise, pick the winner w by searching from `last+1` upward, wrapping modulo NREQ.
  - Next state is LOAD. Register `owner`=w, `last`=w, `load_data`=`req_data`[w], `sel`=1, `gnt`[w]=1, `busy`=1.
- **LOAD** (exactly one cycle)
  - The datapath captures `load_data` at the end of this cycle.
  - Next state is RUN. `sel`=0, `gnt`=0, run counter loaded with RUN_LEN.
  - `req_data` changes during LOAD are ignored (the value is already registered).
- **RUN**
  - The counter decrements each cycle. The datapath free-increments because `sel`=0.
  - `done`[owner]=1 is asserted during the cycle in which the counter equals 1. The next state is then IDLE, with `busy`=0.
  - Abort: if `req`[owner] is sampled 0 during RUN, the next state is IDLE immediately and no `done` pulse is issued.
- Requests from non-owners during LOAD/RUN are held pending and arbitrated in the next IDLE cycle.
- A requester that keeps `req` high after its `done` is treated as a new request. The RR pointer makes it lowest priority.
- There is always at least one IDLE cycle between consecutive grants.
- Counter widths: run counter is $clog2(RUN_LEN+1) bits. Pointer arithmetic wraps modulo NREQ, with no out-of-range index for non-power-of-2 NREQ.

## Timing

- Cycle c0 (IDLE): `req`[i] sampled high.
- Cycle c1 (LOAD): `sel`=1, `gnt`[i]=1, `load_data`=`req_data`[i] as sampled at the end of c0, `busy`=1.
- Cycles c2 to c(1+RUN_LEN) (RUN): `sel`=0. The datapath register holds D in c2 and D+RUN_LEN-1 in c(1+RUN_LEN), wrapping mod 2^DW.
- `done`[i]=1 only in c(1+RUN_LEN); `busy` falls at c(2+RUN_LEN), which is IDLE.
- Grant latency from an idle block is 1 cycle. Minimum grant-to-grant spacing is RUN_LEN+2 cycles.
- Asynchronous reset mid-LOAD/RUN: all outputs go to reset values immediately, with no `done`. After `rstn` rises, arbitration restarts with requester 0 at top priority.
- `gnt` and `done` are never both high in the same cycle (RUN_LEN≥1).

## Test plan

- **Single requester:** reset, then `req`[2]=1 with `req_data`[2]=8'h05 and RUN_LEN=8.
  - `gnt`[2] pulses in c1 with `load_data`=8'h05 and `sel`=1.
  - `done`[2] pulses in c9; `busy` is high for c1–c9; `owner`=2.
  - The datapath register reads 8'h05 in c2 and 8'h0C in c9.
- **Round-robin fairness:** all four `req` held high continuously after reset.
  - Grant order is 0,1,2,3,0.
  - Each grant is exactly 10 cycles after the previous one.
- **Abort:** `req`[1] granted, then dropped at the 3rd RUN cycle.
  - No `done`; `busy`=0 on the next cycle.
  - A pending `req`[3] is granted one cycle after that.
- **Wrap-around:** `req_data`=8'hFD with RUN_LEN=8.
  - The datapath register runs FD, FE, FF, 00, ..., 04.
  - `done` is still issued on the 8th RUN cycle.
- **Reset mid-run:** assert `rstn`=0 during RUN.
  - `sel`, `gnt`, `done`, `busy`, `owner` and `load_data` are 0 within the same cycle.
  - After release, with `req`[0] and `req`[3] both high, requester 0 wins.
- **Pending while busy:** `req`[0] granted; `req`[1] rises in its LOAD cycle.
  - `gnt`[1] pulses exactly one IDLE cycle after `done`[0].
  - `req_data`[1] is sampled in that IDLE cycle.
